seq_divider: RTL

// - Multi-cycle unsigned integer divider: quotient and remainder of dividend_i / divisor_i.
// - Inverse of the adder utilities: one trial subtraction per cycle, restoring algorithm.
// - Sits in std/utils beside the adders. Serves execution units that cannot afford a combinational divide.
// - Start/valid/ack handshake on both sides.
//

---
 rtl/div_pkg.sv | 17 +
 rtl/seq_divider_if.sv | 43 ++++
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 118 +++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Imported by the interface, the trial-subtract step and the top level.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    localparam int DEFAULT_WORD_WIDTH = 8;

    function automatic int cnt_width(input int word_width);
        return $clog2(word_width);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result handshake bundle between a requester and seq_divider.
// master = requester side, slave = divider side.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) ();

    logic                  start_i;
    logic [WORD_WIDTH-1:0] dividend_i;
    logic [WORD_WIDTH-1:0] divisor_i;
    logic                  ready_o;
    logic                  valid_o;
    logic                  ack_i;
    logic [WORD_WIDTH-1:0] quotient_o;
    logic [WORD_WIDTH-1:0] remainder_o;
    logic                  div_zero_o;

    modport master (
        output start_i,
        output dividend_i,
        output divisor_i,
        output ack_i,
        input  ready_o,
        input  valid_o,
        input  quotient_o,
        input  remainder_o,
        input  div_zero_o
    );

    modport slave (
        input  start_i,
        input  dividend_i,
        input  divisor_i,
        input  ack_i,
        output ready_o,
        output valid_o,
        output quotient_o,
        output remainder_o,
        output div_zero_o
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted partial remainder, keeping the difference when it is non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic [WORD_WIDTH:0]   rem_shift_i,
    input  logic [WORD_WIDTH-1:0] divisor_i,
    output logic [WORD_WIDTH-1:0] rem_next_o,
    output logic                  q_bit_o
);

    logic [WORD_WIDTH:0] diff;

    // The extra top bit acts as the borrow/sign of the trial subtract.
    always_comb begin
        diff = rem_shift_i
             + ~{1'b0, divisor_i}
             + {{WORD_WIDTH{1'b0}}, 1'b1};
        q_bit_o = ~diff[WORD_WIDTH];
        if (q_bit_o) begin
            rem_next_o = diff[WORD_WIDTH-1:0];
        end else begin
            rem_next_o = rem_shift_i[WORD_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero short-circuits to an all-ones quotient and remainder = dividend.
module seq_divider
    import div_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input logic          clk_i,
    input logic          rst_i,
    seq_divider_if.slave bus
);

    localparam int CNT_W = cnt_width(WORD_WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WORD_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] rem_q, rem_d;
    logic [WORD_WIDTH-1:0] q_q, q_d;
    logic [WORD_WIDTH-1:0] dvs_q, dvs_d;
    logic [WORD_WIDTH-1:0] quot_q, quot_d;
    logic [WORD_WIDTH-1:0] remo_q, remo_d;
    logic                  dz_q, dz_d;

    logic [WORD_WIDTH:0]   rem_shift;
    logic [WORD_WIDTH-1:0] step_rem;
    logic                  step_q;
    logic [WORD_WIDTH-1:0] q_shifted;

    assign rem_shift = {rem_q, q_q[WORD_WIDTH-1]};
    assign q_shifted = {q_q[WORD_WIDTH-2:0], step_q};

    div_step #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_step (
        .rem_shift_i (rem_shift),
        .divisor_i   (dvs_q),
        .rem_next_o  (step_rem),
        .q_bit_o     (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    dz_d  = 1'b0;
                    dvs_d = bus.divisor_i;
                    if (bus.divisor_i == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        remo_d  = bus.dividend_i;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = CALC;
                        rem_d   = '0;
                        q_d     = bus.dividend_i;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                q_d   = q_shifted;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quot_d  = q_shifted;
                    remo_d  = step_rem;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                if (bus.ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.ready_o     = (state_q == IDLE);
    assign bus.valid_o     = (state_q == DONE);
    assign bus.quotient_o  = quot_q;
    assign bus.remainder_o = remo_q;
    assign bus.div_zero_o  = dz_q;

endmodule
